// File: rtl/mem2_stage_pkg.sv
// Shared types and helpers for the memory-stage-2 datapath: access sizes,
// the latched control entry and the alignment check.
package mem2_stage_pkg;

  localparam int CACHE_WIDTHE = 6;
  localparam int REG_IDX_W    = 5;
  localparam int DW           = 2 ** CACHE_WIDTHE;
  localparam int AW           = CACHE_WIDTHE - 3;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic                 load;
    logic                 regwr;
    logic [REG_IDX_W-1:0] rdidx;
    logic [AW-1:0]        addrlow;
    mem_size_e            size;
    logic                 uns;
  } mem2_ctrl_t;

  function automatic logic is_misaligned(input mem_size_e size, input logic [AW-1:0] addrlow);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = addrlow[0];
      MEM_W:   mis = |addrlow[1:0];
      MEM_D:   mis = |addrlow;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem2_stage_align_bytes_sel.sv
// Combinational byte-lane select and sign/zero extension of a load result.
module align_bytes_sel
  import mem2_stage_pkg::*;
#(
  parameter int CACHE_WIDTHE_P = CACHE_WIDTHE
) (
  input  logic [(2**CACHE_WIDTHE_P)-1:0] data,
  input  logic [CACHE_WIDTHE_P-4:0]      addrlow,
  input  mem_size_e                      size,
  input  logic                           uns,
  output logic [(2**CACHE_WIDTHE_P)-1:0] result
);

  localparam int W = 2 ** CACHE_WIDTHE_P;

  logic [W-1:0] shifted_s;

  // Move the addressed lane down to bit 0, then extend per access size.
  always_comb begin
    shifted_s = data >> {addrlow, 3'b000};
    result    = shifted_s;
    case (size)
      MEM_B:   result = uns ? {{(W-8){1'b0}},  shifted_s[7:0]}
                            : {{(W-8){shifted_s[7]}},   shifted_s[7:0]};
      MEM_H:   result = uns ? {{(W-16){1'b0}}, shifted_s[15:0]}
                            : {{(W-16){shifted_s[15]}}, shifted_s[15:0]};
      MEM_W:   result = uns ? {{(W-32){1'b0}}, shifted_s[31:0]}
                            : {{(W-32){shifted_s[31]}}, shifted_s[31:0]};
      MEM_D:   result = shifted_s;
      default: result = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem2_stage.sv
// Memory stage 2: consumes SRAM read data, aligns loads, and presents a
// registered writeback entry; a one-entry skid keeps SRAM data across stalls.
module mem2_stage
  import mem2_stage_pkg::*;
#(
  parameter int CACHE_WIDTHE = mem2_stage_pkg::CACHE_WIDTHE,
  parameter int REG_IDX_W    = mem2_stage_pkg::REG_IDX_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iValid,
  output logic                         oReady,
  input  logic                         iLoad,
  input  logic                         iRegWr,
  input  logic [REG_IDX_W-1:0]         iRdIdx,
  input  logic [CACHE_WIDTHE-4:0]      iAddrLow,
  input  logic [1:0]                   iSize,
  input  logic                         iUnsigned,
  input  logic [(2**CACHE_WIDTHE)-1:0] iAluRes,
  input  logic [(2**CACHE_WIDTHE)-1:0] iSramRdData,
  input  logic                         iFlush,
  output logic                         oValid,
  input  logic                         iReady,
  output logic                         oRegWr,
  output logic [REG_IDX_W-1:0]         oRdIdx,
  output logic [(2**CACHE_WIDTHE)-1:0] oWbData,
  output logic                         oMisalign
);

  localparam int W = 2 ** CACHE_WIDTHE;

  mem2_ctrl_t           pend_ctrl_r;
  logic                 pend_valid_r;
  logic [W-1:0]         pend_alu_r;
  logic                 skid_valid_r;
  logic [W-1:0]         skid_data_r;
  logic                 out_valid_r;
  logic                 out_regwr_r;
  logic [REG_IDX_W-1:0] out_rdidx_r;
  logic [W-1:0]         out_data_r;
  logic                 out_mis_r;

  logic                 accept_s;
  logic                 out_load_s;
  logic [W-1:0]         src_data_s;
  logic [W-1:0]         aligned_s;
  logic                 mis_s;
  logic [W-1:0]         wb_data_s;
  logic                 wb_regwr_s;

  assign oReady     = !pend_valid_r || !out_valid_r || iReady;
  assign accept_s   = iValid && oReady && !iFlush;
  assign out_load_s = pend_valid_r && (!out_valid_r || iReady);

  assign oValid    = out_valid_r;
  assign oRegWr    = out_regwr_r;
  assign oRdIdx    = out_rdidx_r;
  assign oWbData   = out_data_r;
  assign oMisalign = out_mis_r;

  align_bytes_sel #(.CACHE_WIDTHE_P(CACHE_WIDTHE)) u_align (
    .data    (src_data_s),
    .addrlow (pend_ctrl_r.addrlow),
    .size    (pend_ctrl_r.size),
    .uns     (pend_ctrl_r.uns),
    .result  (aligned_s)
  );

  // Pick the data source for the pend entry and form the writeback value.
  always_comb begin
    src_data_s = pend_alu_r;
    mis_s      = 1'b0;
    wb_data_s  = pend_alu_r;
    wb_regwr_s = pend_ctrl_r.regwr;
    if (skid_valid_r) begin
      src_data_s = skid_data_r;
    end else if (pend_ctrl_r.load) begin
      src_data_s = iSramRdData;
    end else begin
      src_data_s = pend_alu_r;
    end
    if (pend_ctrl_r.load) begin
      mis_s      = is_misaligned(pend_ctrl_r.size, pend_ctrl_r.addrlow);
      wb_data_s  = mis_s ? {W{1'b0}} : aligned_s;
      wb_regwr_s = pend_ctrl_r.regwr && !mis_s;
    end else begin
      wb_data_s  = src_data_s;
      wb_regwr_s = pend_ctrl_r.regwr;
    end
  end

  // Pend entry: control fields and ALU result of the op accepted last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_r <= 1'b0;
      pend_ctrl_r  <= '0;
      pend_alu_r   <= {W{1'b0}};
    end else if (iFlush) begin
      pend_valid_r <= 1'b0;
    end else if (accept_s) begin
      pend_valid_r        <= 1'b1;
      pend_ctrl_r.load    <= iLoad;
      pend_ctrl_r.regwr   <= iRegWr;
      pend_ctrl_r.rdidx   <= iRdIdx;
      pend_ctrl_r.addrlow <= iAddrLow;
      pend_ctrl_r.size    <= mem_size_e'(iSize);
      pend_ctrl_r.uns     <= iUnsigned;
      pend_alu_r          <= iAluRes;
    end else if (out_load_s) begin
      pend_valid_r <= 1'b0;
    end
  end

  // Skid: SRAM dout is only valid for one cycle, so hold it while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
    end else if (iFlush || out_load_s) begin
      skid_valid_r <= 1'b0;
    end else if (pend_valid_r && pend_ctrl_r.load && !skid_valid_r) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= iSramRdData;
    end
  end

  // Writeback output register and its valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_regwr_r <= 1'b0;
      out_rdidx_r <= {REG_IDX_W{1'b0}};
      out_data_r  <= {W{1'b0}};
      out_mis_r   <= 1'b0;
    end else if (iFlush) begin
      out_valid_r <= 1'b0;
    end else if (out_load_s) begin
      out_valid_r <= 1'b1;
      out_regwr_r <= wb_regwr_s;
      out_rdidx_r <= pend_ctrl_r.rdidx;
      out_data_r  <= wb_data_s;
      out_mis_r   <= mis_s;
    end else if (iReady) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem2_stage.sv
// Directed, table-driven bench for mem2_stage plus multi-cycle stall/flush sequences.
module tb_mem2_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iValid, iLoad, iRegWr, iUnsigned, iFlush, iReady;
  logic [4:0]  iRdIdx;
  logic [2:0]  iAddrLow;
  logic [1:0]  iSize;
  logic [63:0] iAluRes, iSramRdData;
  logic        oReady, oValid, oRegWr, oMisalign;
  logic [4:0]  oRdIdx;
  logic [63:0] oWbData;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem2_stage dut (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .oReady(oReady), .iLoad(iLoad),
    .iRegWr(iRegWr), .iRdIdx(iRdIdx), .iAddrLow(iAddrLow), .iSize(iSize),
    .iUnsigned(iUnsigned), .iAluRes(iAluRes), .iSramRdData(iSramRdData),
    .iFlush(iFlush), .oValid(oValid), .iReady(iReady), .oRegWr(oRegWr),
    .oRdIdx(oRdIdx), .oWbData(oWbData), .oMisalign(oMisalign)
  );

  typedef struct {
    logic        load;
    logic        regwr;
    logic [4:0]  rd;
    logic [2:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] alu;
    logic [63:0] sram;
    logic [63:0] exp_wb;
    logic        exp_regwr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive_op(input logic load, input logic regwr, input logic [4:0] rd,
                          input logic [2:0] off, input logic [1:0] size, input logic uns,
                          input logic [63:0] alu);
    iValid = 1'b1; iLoad = load; iRegWr = regwr; iRdIdx = rd;
    iAddrLow = off; iSize = size; iUnsigned = uns; iAluRes = alu;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  3'd3, 2'd0, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 5'd6,  3'd4, 2'd2, 1'b1, 64'h0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd7,  3'd4, 2'd2, 1'b0, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 5'd8,  3'd6, 2'd1, 1'b0, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_FFFF_8765, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 5'd9,  3'd2, 2'd1, 1'b1, 64'h0, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd10, 3'd1, 2'd1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 5'd11, 3'd2, 2'd2, 1'b1, 64'h0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 5'd12, 3'd0, 2'd3, 1'b0, 64'h0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 5'd13, 3'd4, 2'd3, 1'b1, 64'h0, 64'h8123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 5'd14, 3'd3, 2'd1, 1'b0, 64'hDEAD_BEEF_0000_1234, 64'h5555_5555_5555_5555, 64'hDEAD_BEEF_0000_1234, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 5'd15, 3'd7, 2'd0, 1'b1, 64'h0, 64'hFE00_0000_0000_0000, 64'h0000_0000_0000_00FE, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 5'd16, 3'd5, 2'd0, 1'b0, 64'h0, 64'h0000_7F00_0000_0000, 64'h0000_0000_0000_007F, 1'b0, 1'b0};

    // Reset held with an op presented.
    rst_n = 1'b0; iFlush = 1'b0; iReady = 1'b1; iSramRdData = 64'h0;
    drive_op(1'b0, 1'b1, 5'd31, 3'd0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    chk("rst_ovalid", {63'd0, oValid}, 64'd0);
    chk("rst_oready", {63'd0, oReady}, 64'd1);
    chk("rst_wbdata", oWbData, 64'd0);
    chk("rst_regwr", {63'd0, oRegWr}, 64'd0);
    chk("rst_rdidx", {59'd0, oRdIdx}, 64'd0);
    chk("rst_mis", {63'd0, oMisalign}, 64'd0);
    iValid = 1'b0;
    rst_n = 1'b1;

    // Table vectors: one op each, no stall.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_op(vecs[i].load, vecs[i].regwr, vecs[i].rd, vecs[i].off, vecs[i].size,
               vecs[i].uns, vecs[i].alu);
      iSramRdData = ~vecs[i].sram;
      @(negedge clk);
      chk($sformatf("v%0d_lat", i), {63'd0, oValid}, 64'd0);
      iValid = 1'b0;
      iSramRdData = vecs[i].sram;
      @(negedge clk);
      iSramRdData = 64'hBAD0_BAD0_BAD0_BAD0;
      chk($sformatf("v%0d_valid", i), {63'd0, oValid}, 64'd1);
      chk($sformatf("v%0d_wb", i), oWbData, vecs[i].exp_wb);
      chk($sformatf("v%0d_regwr", i), {63'd0, oRegWr}, {63'd0, vecs[i].exp_regwr});
      chk($sformatf("v%0d_rd", i), {59'd0, oRdIdx}, {59'd0, vecs[i].rd});
      chk($sformatf("v%0d_mis", i), {63'd0, oMisalign}, {63'd0, vecs[i].exp_mis});
    end

    // Back-to-back ALU ops: 1,2,3 on consecutive cycles.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        chk($sformatf("b2b_valid%0d", k), {63'd0, oValid}, 64'd1);
        chk($sformatf("b2b_data%0d", k), oWbData, 64'(k - 1));
      end
      if (k < 3) drive_op(1'b0, 1'b1, 5'(k + 1), 3'd0, 2'd3, 1'b0, 64'(k + 1));
      else iValid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_drain", {63'd0, oValid}, 64'd0);

    // Backpressure: two loads stalled, SRAM goes to garbage, third op waits.
    iReady = 1'b0;
    drive_op(1'b1, 1'b1, 5'd1, 3'd0, 2'd3, 1'b0, 64'h0);
    @(negedge clk);
    iSramRdData = 64'h1111_2222_3333_4444;
    drive_op(1'b1, 1'b1, 5'd2, 3'd4, 2'd2, 1'b1, 64'h0);
    @(negedge clk);
    iSramRdData = 64'hCAFE_F00D_0000_0000;
    iValid = 1'b0;
    @(negedge clk);
    iSramRdData = 64'hDEAD_DEAD_DEAD_DEAD;
    chk("bp_oready_low", {63'd0, oReady}, 64'd0);
    drive_op(1'b0, 1'b1, 5'd3, 3'd0, 2'd3, 1'b0, 64'h33);
    @(negedge clk);
    iSramRdData = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clk);
    chk("bp_hold_valid", {63'd0, oValid}, 64'd1);
    chk("bp_hold_data", oWbData, 64'h1111_2222_3333_4444);
    chk("bp_hold_rd", {59'd0, oRdIdx}, 64'd1);
    iReady = 1'b1;
    #1;
    chk("bp_oready_high", {63'd0, oReady}, 64'd1);
    @(negedge clk);
    iValid = 1'b0;
    chk("bp_skid_data", oWbData, 64'h0000_0000_CAFE_F00D);
    chk("bp_skid_rd", {59'd0, oRdIdx}, 64'd2);
    @(negedge clk);
    chk("bp_third_valid", {63'd0, oValid}, 64'd1);
    chk("bp_third_data", oWbData, 64'h33);
    chk("bp_third_rd", {59'd0, oRdIdx}, 64'd3);
    @(negedge clk);
    chk("bp_no_dup", {63'd0, oValid}, 64'd0);

    // Flush with pend and output occupied and a new op presented.
    iReady = 1'b0;
    drive_op(1'b0, 1'b1, 5'd20, 3'd0, 2'd3, 1'b0, 64'hA);
    @(negedge clk);
    drive_op(1'b0, 1'b1, 5'd21, 3'd0, 2'd3, 1'b0, 64'hB);
    @(negedge clk);
    iFlush = 1'b1;
    drive_op(1'b0, 1'b1, 5'd22, 3'd0, 2'd3, 1'b0, 64'hC);
    @(negedge clk);
    iFlush = 1'b0; iValid = 1'b0; iReady = 1'b1;
    chk("fl_ovalid", {63'd0, oValid}, 64'd0);
    repeat (2) @(negedge clk);
    chk("fl_not_accepted", {63'd0, oValid}, 64'd0);
    drive_op(1'b0, 1'b1, 5'd23, 3'd0, 2'd3, 1'b0, 64'hD);
    @(negedge clk);
    iValid = 1'b0;
    @(negedge clk);
    chk("fl_next_valid", {63'd0, oValid}, 64'd1);
    chk("fl_next_data", oWbData, 64'hD);
    chk("fl_next_rd", {59'd0, oRdIdx}, 64'd23);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
